// File: rtl/nios_adc_sw_pio_if.sv
// Avalon-MM slave bus bundle for the switch/key input PIO: word address,
// select, write strobe and data toward the slave; read data and irq back.
interface nios_adc_sw_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );
endinterface

// File: rtl/nios_adc_sw_pio.sv
// Switch/key input PIO: synchronised input bus, per-bit edge capture and maskable irq.
// Optional per-bit debounce filter is compiled in with NIOS_ADC_SW_PIO_DEBOUNCE_EN.
module nios_adc_sw_pio #(
    parameter int WIDTH           = 10,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    nios_adc_sw_pio_if.slave     bus,
    input  logic [WIDTH-1:0]     in_port
);

    localparam int         EDGE_RISE = 0;
    localparam int         EDGE_FALL = 1;
    localparam logic [1:0] WARM_DONE = 2'd3;

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [1:0]       warm_cnt_q, warm_cnt_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] f_s;
    logic [WIDTH-1:0] edge_raw_s;
    logic [WIDTH-1:0] edge_s;
    logic [WIDTH-1:0] clr_s;
    logic             warm_s;
    logic             wr_s;
    logic             unused_wdata_s;

    // Warm-up counter: edge detection stays off until three cycles after reset release.
    always_comb begin
        warm_s = (warm_cnt_q != WARM_DONE);
        if (warm_s) begin
            warm_cnt_d = warm_cnt_q + 2'd1;
        end else begin
            warm_cnt_d = warm_cnt_q;
        end
    end

    // Two-flop synchroniser input chain.
    always_comb begin
        s1_d = in_port;
        s2_d = s1_q;
    end

`ifdef NIOS_ADC_SW_PIO_DEBOUNCE_EN
    localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]         f_q, f_d;
    logic [WIDTH-1:0][CW-1:0] db_cnt_q, db_cnt_d;

    // Debounce: a bit moves to f only after s2 has differed from f for DEBOUNCE_CYCLES cycles.
    always_comb begin
        f_d      = f_q;
        db_cnt_d = db_cnt_q;
        if (warm_s) begin
            f_d      = s2_q;
            db_cnt_d = {(WIDTH*CW){1'b0}};
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s2_q[i] == f_q[i]) begin
                    db_cnt_d[i] = {CW{1'b0}};
                end else if (db_cnt_q[i] == DB_LAST) begin
                    f_d[i]      = s2_q[i];
                    db_cnt_d[i] = {CW{1'b0}};
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + {{(CW-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // Previous-value tracking; during warm-up p loads the same value as f so nothing looks like an edge.
    always_comb begin
        f_s = f_q;
        if (warm_s) begin
            p_d = f_d;
        end else begin
            p_d = f_q;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_q      <= {WIDTH{1'b0}};
            db_cnt_q <= {(WIDTH*CW){1'b0}};
        end else begin
            f_q      <= f_d;
            db_cnt_q <= db_cnt_d;
        end
    end
`else
    localparam int UNUSED_DEBOUNCE_CYCLES = DEBOUNCE_CYCLES;

    // Without debounce the filtered value is the synchroniser output itself.
    always_comb begin
        f_s = s2_q;
        p_d = s2_q;
    end
`endif

    // Edge selection; masked to zero while warming up.
    always_comb begin
        case (EDGE_TYPE)
            EDGE_RISE: edge_raw_s = f_s & ~p_q;
            EDGE_FALL: edge_raw_s = ~f_s & p_q;
            default:   edge_raw_s = f_s ^ p_q;
        endcase
        if (warm_s) begin
            edge_s = {WIDTH{1'b0}};
        end else begin
            edge_s = edge_raw_s;
        end
    end

    // Register writes: irqmask load, edgecapture write-1-clear with set taking priority.
    always_comb begin
        wr_s           = bus.chipselect & ~bus.write_n;
        unused_wdata_s = ^bus.writedata;
        if (wr_s && (bus.address == 2'd2)) begin
            irqmask_d = bus.writedata[WIDTH-1:0];
        end else begin
            irqmask_d = irqmask_q;
        end
        if (wr_s && (bus.address == 2'd3)) begin
            clr_s = bus.writedata[WIDTH-1:0];
        end else begin
            clr_s = {WIDTH{1'b0}};
        end
        edgecap_d = (edgecap_q & ~clr_s) | edge_s;
    end

    // Read mux, registered every cycle regardless of chipselect.
    always_comb begin
        case (bus.address)
            2'd0:    readdata_d = 32'(f_s);
            2'd1:    readdata_d = 32'h0000_0000;
            2'd2:    readdata_d = 32'(irqmask_q);
            2'd3:    readdata_d = 32'(edgecap_q);
            default: readdata_d = 32'h0000_0000;
        endcase
    end

    // Main state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q       <= {WIDTH{1'b0}};
            s2_q       <= {WIDTH{1'b0}};
            p_q        <= {WIDTH{1'b0}};
            irqmask_q  <= {WIDTH{1'b0}};
            edgecap_q  <= {WIDTH{1'b0}};
            warm_cnt_q <= 2'd0;
            readdata_q <= 32'h0000_0000;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            p_q        <= p_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            warm_cnt_q <= warm_cnt_d;
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_nios_adc_sw_pio.sv
// Directed bench for nios_adc_sw_pio: a rising-edge instance and an any-edge instance
// share clock and reset; read expectations go through a scoreboard queue.
module tb_nios_adc_sw_pio;

`ifdef NIOS_ADC_SW_PIO_DEBOUNCE_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] in0;
    logic [9:0] in2;
    int         total = 0;
    int         bad   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    nios_adc_sw_pio_if bus0 ();
    nios_adc_sw_pio_if bus2 ();

    nios_adc_sw_pio #(.WIDTH(10), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(16)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0.slave), .in_port(in0)
    );

    nios_adc_sw_pio #(.WIDTH(10), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(16)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2.slave), .in_port(in2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input int u, input logic [1:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] e;
        logic [31:0] obs;
        if (u == 0) bus0.address = a;
        else        bus2.address = a;
        exp_q.push_back(exp);
        @(negedge clk);
        obs = (u == 0) ? bus0.readdata : bus2.readdata;
        e   = exp_q.pop_front();
        check(tag, obs, e);
    endtask

    task automatic wr(input int u, input logic [1:0] a, input logic [31:0] d);
        if (u == 0) begin
            bus0.address = a; bus0.writedata = d; bus0.chipselect = 1'b1; bus0.write_n = 1'b0;
        end else begin
            bus2.address = a; bus2.writedata = d; bus2.chipselect = 1'b1; bus2.write_n = 1'b0;
        end
        @(negedge clk);
        bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
        bus2.chipselect = 1'b0; bus2.write_n = 1'b1;
    endtask

    initial begin
        bus0.address = 2'd0; bus0.chipselect = 1'b0; bus0.write_n = 1'b1; bus0.writedata = 32'h0;
        bus2.address = 2'd0; bus2.chipselect = 1'b0; bus2.write_n = 1'b1; bus2.writedata = 32'h0;
        reset_n = 1'b0;
        in0 = 10'h3FF;
        in2 = 10'h3FF;

        // Reset state, then inputs held high through reset must not capture
        cycles(3);
        check("rst_rd", bus0.readdata, 32'h0);
        check("rst_irq", {31'd0, bus0.irq}, 32'd0);
        reset_n = 1'b1;
        cycles(10);
        rd(0, 2'd3, 32'h0, "warm_ec");
        rd(0, 2'd0, 32'h3FF, "warm_data");
        check("warm_irq", {31'd0, bus0.irq}, 32'd0);
        rd(1, 2'd3, 32'h0, "warm_ec_any");

        // Falling edges ignored by rising type; bit0 rise latency and irq
        in0 = 10'h000;
        cycles(LAT + 3);
        rd(0, 2'd3, 32'h0, "fall_ignored");
        wr(0, 2'd2, 32'h1);
        in0 = 10'h001;
        cycles(LAT);
        check("irq_early", {31'd0, bus0.irq}, 32'd0);
        cycles(1);
        check("irq_set", {31'd0, bus0.irq}, 32'd1);
        rd(0, 2'd3, 32'h1, "ec_bit0");
        wr(0, 2'd3, 32'h1);
        check("irq_clr", {31'd0, bus0.irq}, 32'd0);
        rd(0, 2'd3, 32'h0, "ec_cleared");

        // Clear of bit3 on the same edge its rise is captured: set wins
        in0 = 10'h009;
        cycles(LAT);
        wr(0, 2'd3, 32'h8);
        rd(0, 2'd3, 32'h8, "set_wins");
        wr(0, 2'd3, 32'h8);
        rd(0, 2'd3, 32'h0, "clr_bit3");

        // Masking, reserved address, read-only data, upper bits zero
        wr(0, 2'd2, 32'h0);
        in0 = 10'h0F9;
        cycles(LAT + 2);
        rd(0, 2'd3, 32'hF0, "ec_f0");
        check("irq_masked", {31'd0, bus0.irq}, 32'd0);
        wr(0, 2'd2, 32'h10);
        check("irq_unmask", {31'd0, bus0.irq}, 32'd1);
        rd(0, 2'd2, 32'h10, "mask_rd");
        rd(0, 2'd1, 32'h0, "rsv_rd");
        wr(0, 2'd1, 32'hFFFF_FFFF);
        rd(0, 2'd1, 32'h0, "rsv_wr");
        wr(0, 2'd0, 32'h0);
        rd(0, 2'd0, 32'hF9, "data_ro");
        wr(0, 2'd2, 32'hFFFF_FFFF);
        rd(0, 2'd2, 32'h3FF, "mask_upper0");

        // Reset mid-operation drops pending captures immediately
        check("irq_pre_rst", {31'd0, bus0.irq}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_async_irq", {31'd0, bus0.irq}, 32'd0);
        check("rst_async_rd", bus0.readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        cycles(10);
        rd(0, 2'd3, 32'h0, "rst_lost");
        rd(0, 2'd2, 32'h0, "mask_rst");

        // Any-edge instance: bit9 toggled twice, cleared in between
        in2 = 10'h1FF;
        cycles(LAT + 2);
        rd(1, 2'd3, 32'h200, "any_fall");
        wr(1, 2'd3, 32'h200);
        rd(1, 2'd3, 32'h0, "any_clr");
        cycles(15);
        in2 = 10'h3FF;
        cycles(LAT + 2);
        rd(1, 2'd3, 32'h200, "any_rise");
        wr(1, 2'd2, 32'h200);
        check("any_irq", {31'd0, bus2.irq}, 32'd1);

`ifdef NIOS_ADC_SW_PIO_DEBOUNCE_EN
        // Short glitch filtered out; long pulse reaches f 16 cycles after s2
        in0 = 10'h0F8;
        cycles(30);
        wr(0, 2'd3, 32'h3FF);
        in0 = 10'h0F9;
        cycles(10);
        in0 = 10'h0F8;
        cycles(40);
        rd(0, 2'd3, 32'h0, "db_glitch");
        rd(0, 2'd0, 32'hF8, "db_data");
        in0 = 10'h0F9;
        cycles(16);
        rd(0, 2'd0, 32'hF8, "db_f_early");
        cycles(1);
        rd(0, 2'd0, 32'hF9, "db_f_rise");
        cycles(2);
        rd(0, 2'd3, 32'h1, "db_capture");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nios_adc_sw_pio.md
# nios_ADC_sw_pio

Avalon-MM slave input port that samples a 10-bit external bus (board switches/keys), latches rising/falling/any edges per bit, and raises a maskable interrupt to the Nios II. It is the read-direction counterpart of the system's LED output PIO and uses the same 2-bit word address map style on the same system clock domain.

## Interface
- WIDTH, 10, input bus width (1..32)
- EDGE_TYPE, 0, edge capture type: 0 rising, 1 falling, 2 any
- DEBOUNCE_CYCLES, 16, required stable cycles per bit (used only with debounce compiled in; ≥2)
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  WIDTH  asynchronous external inputs
- readdata  out  32  registered read data; upper 32-WIDTH bits always 0
- irq  out  1  level interrupt to CPU

## Operation
- Register map: 0 data (RO, filtered input); 1 reserved (reads 0, writes ignored); 2 irqmask (RW, WIDTH bits); 3 edgecapture (read; write 1 clears bit, write 0 no effect).
- Writes occur when chipselect && !write_n. Writes to address 0 and 1 are ignored.
- Input path: 2-flop synchronizer s1→s2; filtered value f = s2 (no debounce) or debounce output; prev register p <= f each cycle.
- Edge detect per bit: rising f & ~p, falling ~f & p, any f ^ p.
- edgecapture[i] <= 1 on detected edge; cleared by write-1; set wins over a simultaneous clear of the same bit.
- irq = |(edgecapture & irqmask), combinational from registers.
- Warm-up: 3-cycle counter after reset release; during warm-up f loads s2 directly, p follows f, edge detection is suppressed. Inputs held constant through reset therefore produce no capture.
- Reset values: s1, s2, f, p, irqmask, edgecapture, readdata = 0; irq = 0; warm-up counter = 0.
- Reset asserted mid-operation clears everything immediately; pending captures are lost.

## Timing
- in_port change sampled at edge N: s2 updates at N+1; f at N+1 (no debounce); edgecapture bit set at edge N+2; irq high after N+2 if masked in.
- Read latency 1: readdata <= mux(address) at every rising edge regardless of chipselect; CPU samples one cycle after address presented. No wait states.
- Write takes effect at the edge where write is asserted; irq reflects a write-1-clear or mask change in the following cycle.
- Reading edgecapture does not clear it.

## Configuration
- NIOS_ADC_SW_PIO_DEBOUNCE_EN defined: per-bit counter (width clog2(DEBOUNCE_CYCLES+1)); counter clears when s2 == f, else increments; when s2 != f for DEBOUNCE_CYCLES consecutive cycles, f <= s2 and counter clears. Glitches shorter than DEBOUNCE_CYCLES never reach f. Adds DEBOUNCE_CYCLES cycles latency. Counters reset to 0 and are held 0 during warm-up.
- Undefined: no counters; f = s2 path as above; DEBOUNCE_CYCLES ignored.

## Test plan
- Reset with in_port=10'h3FF held, release, wait 10 cycles → edgecapture reads 0, data reads 0x3FF, irq 0.
- EDGE_TYPE=0, irqmask=0x001, in_port bit0 0→1 at edge N → edgecapture=0x001 at N+2, irq 1; write 0x001 to addr 3 → irq 0 next cycle.
- Write-1 clear of bit 3 in the same cycle bit 3's rising edge is detected → edgecapture bit 3 remains 1.
- irqmask=0 with captured 0x0F0 → irq 0; write irqmask=0x010 → irq 1; address 1 reads 0, write to address 0 leaves data unchanged.
- EDGE_TYPE=2, toggle bit 9 twice with 20-cycle spacing, clear between → two captures, readdata=0x200 each time, bits 31:10 zero.
- With NIOS_ADC_SW_PIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=16: 10-cycle pulse on bit 0 → no capture, data 0; 30-cycle pulse → f rises 16 cycles after s2, capture set.
